// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the serial-add sequencer slice.
//   state_t   : sequencer FSM states (IDLE, HOLD, SAMPLE, OUT)
//   N_DEF     : default operand/result width in bits
//   DEPTH_DEF : default operand FIFO depth in pairs
//   HOLD_DEF  : default operand hold time in cycles (serial add time + margin)
package serial_add_pkg;

  localparam int N_DEF     = 64;
  localparam int DEPTH_DEF = 4;
  localparam int HOLD_DEF  = N_DEF + 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    OUT    = 2'd3
  } state_t;

endpackage

// File: rtl/serial_add_sequencer_if.sv
// Bus bundle between the sequencer, its operand producer, the external
// serial adder and the result consumer.
//   in_valid/in_ready/in_a/in_b        : operand pair handshake
//   inp1/inp2/start                    : operands and start pulse to the adder
//   sum/cout                           : adder result and carry-out
//   res_valid/res_ready                : result handshake
//   res_sum/res_cout/res_ovf           : captured result, carry, signed overflow
// slave  : the sequencer's view
// master : the environment's view (producer, adder and consumer)
interface serial_add_sequencer_if
  import serial_add_pkg::*;
#(
  parameter int N = N_DEF
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_a;
  logic signed [N-1:0] in_b;
  logic signed [N-1:0] inp1;
  logic signed [N-1:0] inp2;
  logic                start;
  logic signed [N-1:0] sum;
  logic                cout;
  logic                res_valid;
  logic                res_ready;
  logic signed [N-1:0] res_sum;
  logic                res_cout;
  logic                res_ovf;

  modport slave (
    input  in_valid, in_a, in_b, sum, cout, res_ready,
    output in_ready, inp1, inp2, start, res_valid, res_sum, res_cout, res_ovf
  );

  modport master (
    output in_valid, in_a, in_b, sum, cout, res_ready,
    input  in_ready, inp1, inp2, start, res_valid, res_sum, res_cout, res_ovf
  );
endinterface

// File: rtl/serial_add_sequencer_sync_fifo.sv
// Synchronous show-ahead FIFO holding operand pairs.
//   clk, rst : clock and synchronous active-high reset (pointers/occupancy only)
//   push     : write wdata (ignored while full)
//   pop      : drop the head entry (ignored while empty)
//   rdata    : head entry, valid whenever empty is 0
//   full     : occupancy == DEPTH
//   empty    : occupancy == 0
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths behave.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/serial_add_sequencer.sv
// Serial-add sequencer: queues signed operand pairs, presents each pair to an
// external serial adder for HOLD cycles, samples the sum/carry, derives signed
// overflow and offers the result on a valid/ready handshake.
//   clk, rst : clock and synchronous active-high reset
//   bus      : serial_add_sequencer_if.slave (operand, adder and result signals)
// Parameters: N (width), DEPTH (FIFO pairs), HOLD (operand hold cycles).
module serial_add_sequencer #(
  parameter int N     = serial_add_pkg::N_DEF,
  parameter int DEPTH = serial_add_pkg::DEPTH_DEF,
  parameter int HOLD  = N + 2
) (
  input logic                   clk,
  input logic                   rst,
  serial_add_sequencer_if.slave bus
);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  serial_add_pkg::state_t state;
  logic [CW-1:0]          cnt;
  logic signed [N-1:0]    inp1_q;
  logic signed [N-1:0]    inp2_q;
  logic                   start_q;
  logic signed [N-1:0]    res_sum_q;
  logic                   res_cout_q;
  logic                   res_ovf_q;
  logic                   res_valid_q;

  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [2*N-1:0]         fifo_rdata;

  // Overflow of a two's-complement add: equal operand signs, different result sign.
  function automatic logic signed_ovf(input logic signed [N-1:0] a,
                                      input logic signed [N-1:0] b,
                                      input logic signed [N-1:0] s);
    return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  assign bus.in_ready = !fifo_full && !rst;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == serial_add_pkg::IDLE) && !fifo_empty;

  sync_fifo #(
    .WIDTH (2 * N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({bus.in_a, bus.in_b}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= serial_add_pkg::IDLE;
      cnt         <= '0;
      inp1_q      <= '0;
      inp2_q      <= '0;
      start_q     <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        // Load the head pair onto the adder inputs.
        serial_add_pkg::IDLE: begin
          if (pop) begin
            inp1_q  <= fifo_rdata[2*N-1:N];
            inp2_q  <= fifo_rdata[N-1:0];
            start_q <= 1'b1;
            cnt     <= CW'(HOLD - 1);
            state   <= serial_add_pkg::HOLD;
          end
        end
        // Operands stay put while the adder works through the bits.
        serial_add_pkg::HOLD: begin
          if (cnt == '0) state <= serial_add_pkg::SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        // Adder output has settled; capture it.
        serial_add_pkg::SAMPLE: begin
          res_sum_q   <= bus.sum;
          res_cout_q  <= bus.cout;
          res_ovf_q   <= signed_ovf(inp1_q, inp2_q, bus.sum);
          res_valid_q <= 1'b1;
          state       <= serial_add_pkg::OUT;
        end
        // Hold the result until the consumer takes it.
        serial_add_pkg::OUT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= serial_add_pkg::IDLE;
          end
        end
        default: state <= serial_add_pkg::IDLE;
      endcase
    end
  end

  assign bus.inp1      = inp1_q;
  assign bus.inp2      = inp2_q;
  assign bus.start     = start_q;
  assign bus.res_sum   = res_sum_q;
  assign bus.res_cout  = res_cout_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer with a behavioural serial adder and
// a queue of expected results.
module tb_serial_add_sequencer;
  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam int HOLD  = N + 2;

  typedef logic [N+1:0] exp_t;   // {cout, ovf, sum}

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  int   acnt = 0;
  logic [N:0] add_full;

  always #5 clk = ~clk;

  serial_add_sequencer_if #(.N(N)) bus ();

  serial_add_sequencer #(
    .N     (N),
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Serial adder stand-in: the true sum only appears N cycles after start,
  // before that the outputs are inverted so an early sample is wrong.
  always_ff @(posedge clk) begin
    if (bus.start)                  acnt <= 1;
    else if (acnt > 0 && acnt < 1000) acnt <= acnt + 1;
  end
  assign add_full = {1'b0, bus.inp1} + {1'b0, bus.inp2};
  assign bus.sum  = (acnt >= N) ? add_full[N-1:0] : ~add_full[N-1:0];
  assign bus.cout = (acnt >= N) ? add_full[N] : ~add_full[N];

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0] f;
    logic       ovf;
    f   = {1'b0, a} + {1'b0, b};
    ovf = (a[N-1] == b[N-1]) && (f[N-1] != a[N-1]);
    return {f[N], ovf, f[N-1:0]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    w = 0;
    while (!bus.in_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.in_ready) begin
      check("push_timeout", 128'd0, 128'd1);
    end else begin
      @(posedge clk);
      q.push_back(model(a, b));
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int   w;
    exp_t e;
    w = 0;
    while (!bus.res_valid && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (!bus.res_valid) begin
      check({tag, "_timeout"}, 128'd0, 128'd1);
    end else if (q.size() == 0) begin
      check({tag, "_unexpected"}, 128'd1, 128'd0);
    end else begin
      e = q.pop_front();
      check(tag, {bus.res_cout, bus.res_ovf, bus.res_sum}, e);
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int starts;
    int accepted;
    int seen;
    logic rdy;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd0);
    check("rst_inp", {bus.inp1, bus.inp2}, 128'd0);
    check("rst_res", {bus.start, bus.res_valid, bus.res_cout, bus.res_ovf, bus.res_sum}, 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk); #1;

    // Latency, start pulse and a stalled result
    ra = 64'h000000000000000F;
    rb = 64'hFFFFFFFFFFFFFFFC;
    bus.in_a = ra;
    bus.in_b = rb;
    bus.in_valid = 1'b1;
    @(posedge clk);
    q.push_back(model(ra, rb));
    #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    starts = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (bus.start) starts++;
    end while (!bus.res_valid && cyc < 200);
    check("latency", 128'(cyc), 128'(HOLD + 2));
    check("start_pulses", 128'(starts), 128'd1);
    check("inp_hold", {bus.inp1, bus.inp2}, {ra, rb});
    check("r032_literal", {bus.res_cout, bus.res_ovf, bus.res_sum}, {1'b1, 1'b0, 64'hB});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall_stable", {bus.res_valid, bus.start, bus.res_cout, bus.res_ovf, bus.res_sum},
            {1'b1, 1'b0, 1'b1, 1'b0, 64'hB});
    end
    get_result("r032");

    // Signed overflow corners
    push_pair(64'h8000000000000000, 64'h8000000000000000);
    get_result("r033");
    check("r033_literal", {bus.res_cout, bus.res_ovf, bus.res_sum}, {1'b1, 1'b1, 64'h0});
    push_pair(64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF);
    get_result("r034");
    check("r034_literal", {bus.res_cout, bus.res_ovf, bus.res_sum},
          {1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFE});
    push_pair({$urandom, $urandom}, {$urandom, $urandom});
    get_result("rand");

    // Back-to-back pushes with the consumer stalled
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      bus.in_a = ra;
      bus.in_b = rb;
      bus.in_valid = 1'b1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        q.push_back(model(ra, rb));
        accepted++;
      end
      #1;
    end
    bus.in_valid = 1'b0;
    check("burst_accepted", 128'(accepted), 128'(DEPTH + 1));
    check("burst_full", {127'd0, bus.in_ready}, 128'd0);
    for (int i = 0; i < DEPTH + 1; i++) get_result("burst");

    // Reset in the middle of HOLD with two pairs queued
    push_pair(64'd1, 64'd2);
    push_pair(64'd3, 64'd4);
    push_pair(64'd5, 64'd6);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_inp", {bus.inp1, bus.inp2}, 128'd0);
    check("midrst_res", {bus.start, bus.res_valid, bus.res_cout, bus.res_ovf, bus.res_sum}, 128'd0);
    check("midrst_in_ready", {127'd0, bus.in_ready}, 128'd0);
    q.delete();
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    seen = 0;
    for (int i = 0; i < 2 * HOLD + 20; i++) begin
      @(posedge clk); #1;
      if (bus.res_valid || bus.start) seen++;
    end
    check("discarded", 128'(seen), 128'd0);

    // Normal operation after the mid-run reset
    push_pair(64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001);
    get_result("recover");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
